multicycle_control: RTL and testbench

- Multi-cycle MIPS controller FSM; successor to the single-cycle combinational decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared-datapath mux selects and write enables per state.
- Adds a unified-memory ready handshake, illegal-opcode trap, bne/jal/immediate-logic support, and a parametrised ALUOp width.
- Sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/multicycle_control_if.sv | 40 ++++
 rtl/multicycle_control.sv | 223 ++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller (master) and the shared datapath (slave).
// Carries the IR opcode and memory-ready status in, and all mux selects and write enables out.
interface multicycle_control_if #(
   parameter int OP_W    = 6,
   parameter int ALUOP_W = 3,
   parameter int STATE_W = 4
);
   logic [OP_W-1:0]    Op;
   logic               MemReady;
   logic               PCWrite;
   logic               PCWriteCond;
   logic               BranchNE;
   logic               IorD;
   logic               MemRead;
   logic               MemWrite;
   logic               IRWrite;
   logic [1:0]         MemtoReg;
   logic [1:0]         RegDst;
   logic               RegWrite;
   logic               ALUSrcA;
   logic [1:0]         ALUSrcB;
   logic [ALUOP_W-1:0] ALUOp;
   logic [1:0]         PCSource;
   logic               Trap;
   logic [STATE_W-1:0] State;

   modport master (
      input  Op, MemReady,
      output PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             Trap, State
   );

   modport slave (
      output Op, MemReady,
      input  PCWrite, PCWriteCond, BranchNE, IorD, MemRead, MemWrite, IRWrite,
             MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
             Trap, State
   );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS controller: Moore FSM sequencing FETCH/DECODE/EXEC/MEM/WB with registered
// control outputs; only IRWrite/PCWrite in FETCH are gated combinationally by memory ready.
module multicycle_control #(
   parameter int OP_W          = 6,
   parameter int ALUOP_W       = 3,
   parameter int STATE_W       = 4,
   parameter bit MEM_HANDSHAKE = 1'b1
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   multicycle_control_if.master bus
);

   typedef enum logic [3:0] {
      S_FETCH  = 4'd0,
      S_DECODE = 4'd1,
      S_MEMADR = 4'd2,
      S_MEMRD  = 4'd3,
      S_MEMWB  = 4'd4,
      S_MEMWR  = 4'd5,
      S_EXEC_R = 4'd6,
      S_RWB    = 4'd7,
      S_BRANCH = 4'd8,
      S_JUMP   = 4'd9,
      S_EXEC_I = 4'd10,
      S_IWB    = 4'd11,
      S_TRAP   = 4'd12
   } state_t;

   typedef struct packed {
      logic       pcwrite;
      logic       pcwritecond;
      logic       branchne;
      logic       iord;
      logic       memread;
      logic       memwrite;
      logic [1:0] memtoreg;
      logic [1:0] regdst;
      logic       regwrite;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [2:0] aluop;
      logic [1:0] pcsource;
      logic       trap;
   } ctrl_t;

   localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(0);
   localparam logic [OP_W-1:0] OP_J     = OP_W'(2);
   localparam logic [OP_W-1:0] OP_JAL   = OP_W'(3);
   localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(4);
   localparam logic [OP_W-1:0] OP_BNE   = OP_W'(5);
   localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(8);
   localparam logic [OP_W-1:0] OP_SLTI  = OP_W'(10);
   localparam logic [OP_W-1:0] OP_ANDI  = OP_W'(12);
   localparam logic [OP_W-1:0] OP_ORI   = OP_W'(13);
   localparam logic [OP_W-1:0] OP_LW    = OP_W'(35);
   localparam logic [OP_W-1:0] OP_SW    = OP_W'(43);

   localparam logic [2:0] ALU_ADD  = 3'd0;
   localparam logic [2:0] ALU_SUB  = 3'd1;
   localparam logic [2:0] ALU_FUNC = 3'd2;
   localparam logic [2:0] ALU_AND  = 3'd3;
   localparam logic [2:0] ALU_OR   = 3'd4;
   localparam logic [2:0] ALU_SLT  = 3'd5;

   state_t          st;
   state_t          nxt;
   logic [OP_W-1:0] op_q;
   logic [OP_W-1:0] op_nxt;
   ctrl_t           ctl_q;
   logic            rdy;
   logic            fetch_go;

   function automatic state_t decode_target(input logic [OP_W-1:0] op);
      state_t s;
      case (op)
         OP_RTYPE:                          s = S_EXEC_R;
         OP_LW, OP_SW:                      s = S_MEMADR;
         OP_BEQ, OP_BNE:                    s = S_BRANCH;
         OP_J, OP_JAL:                      s = S_JUMP;
         OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: s = S_EXEC_I;
         default:                           s = S_TRAP;
      endcase
      return s;
   endfunction

   // Control word for a state; op is the instruction's latched opcode.
   function automatic ctrl_t ctrl_for(input state_t s, input logic [OP_W-1:0] op);
      ctrl_t c;
      c = '0;
      case (s)
         S_FETCH: begin
            c.memread = 1'b1;
            c.alusrcb = 2'd1;
            c.aluop   = ALU_ADD;
         end
         S_DECODE: begin
            c.alusrcb = 2'd3;
            c.aluop   = ALU_ADD;
         end
         S_MEMADR: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'd2;
            c.aluop   = ALU_ADD;
         end
         S_MEMRD: begin
            c.memread = 1'b1;
            c.iord    = 1'b1;
         end
         S_MEMWB: begin
            c.regwrite = 1'b1;
            c.memtoreg = 2'd1;
            c.regdst   = 2'd0;
         end
         S_MEMWR: begin
            c.memwrite = 1'b1;
            c.iord     = 1'b1;
         end
         S_EXEC_R: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'd0;
            c.aluop   = ALU_FUNC;
         end
         S_RWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'd1;
            c.memtoreg = 2'd0;
         end
         S_BRANCH: begin
            c.alusrca     = 1'b1;
            c.alusrcb     = 2'd0;
            c.aluop       = ALU_SUB;
            c.pcwritecond = 1'b1;
            c.pcsource    = 2'd1;
            c.branchne    = (op == OP_BNE);
         end
         S_JUMP: begin
            c.pcwrite  = 1'b1;
            c.pcsource = 2'd2;
            // jal links the PC+4 already written back during FETCH into $31
            if (op == OP_JAL) begin
               c.regwrite = 1'b1;
               c.regdst   = 2'd2;
               c.memtoreg = 2'd2;
            end
         end
         S_EXEC_I: begin
            c.alusrca = 1'b1;
            c.alusrcb = 2'd2;
            case (op)
               OP_SLTI: c.aluop = ALU_SLT;
               OP_ANDI: c.aluop = ALU_AND;
               OP_ORI:  c.aluop = ALU_OR;
               default: c.aluop = ALU_ADD;
            endcase
         end
         S_IWB: begin
            c.regwrite = 1'b1;
            c.regdst   = 2'd0;
            c.memtoreg = 2'd0;
         end
         S_TRAP: begin
            c.trap = 1'b1;
         end
         default: begin
            c = '0;
         end
      endcase
      return c;
   endfunction

   assign rdy = MEM_HANDSHAKE ? bus.MemReady : 1'b1;

   always_comb begin
      nxt    = S_FETCH;
      op_nxt = (st == S_DECODE) ? bus.Op : op_q;
      case (st)
         S_FETCH:  nxt = rdy ? S_DECODE : S_FETCH;
         S_DECODE: nxt = decode_target(bus.Op);
         S_MEMADR: nxt = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
         S_MEMRD:  nxt = rdy ? S_MEMWB : S_MEMRD;
         S_MEMWR:  nxt = rdy ? S_FETCH : S_MEMWR;
         S_EXEC_R: nxt = S_RWB;
         S_EXEC_I: nxt = S_IWB;
         default:  nxt = S_FETCH;
      endcase
   end

   // State, latched opcode and the next state's control word all update on the same edge,
   // so outputs are registered yet still reflect the current state.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         st    <= S_FETCH;
         op_q  <= '0;
         ctl_q <= ctrl_for(S_FETCH, '0);
      end else begin
         st    <= nxt;
         op_q  <= op_nxt;
         ctl_q <= ctrl_for(nxt, op_nxt);
      end
   end

   // IR and PC+4 may only load once the fetch read has actually returned.
   assign fetch_go = (st == S_FETCH) && rdy;

   assign bus.PCWrite     = ctl_q.pcwrite | fetch_go;
   assign bus.IRWrite     = fetch_go;
   assign bus.PCWriteCond = ctl_q.pcwritecond;
   assign bus.BranchNE    = ctl_q.branchne;
   assign bus.IorD        = ctl_q.iord;
   assign bus.MemRead     = ctl_q.memread;
   assign bus.MemWrite    = ctl_q.memwrite;
   assign bus.MemtoReg    = ctl_q.memtoreg;
   assign bus.RegDst      = ctl_q.regdst;
   assign bus.RegWrite    = ctl_q.regwrite;
   assign bus.ALUSrcA     = ctl_q.alusrca;
   assign bus.ALUSrcB     = ctl_q.alusrcb;
   assign bus.ALUOp       = ALUOP_W'(ctl_q.aluop);
   assign bus.PCSource    = ctl_q.pcsource;
   assign bus.Trap        = ctl_q.trap;
   assign bus.State       = STATE_W'(st);

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: directed test-plan instructions then random instruction streams,
// each expanded into its expected per-cycle state/MemReady trace by a behavioural model.
module tb_multicycle_control;
   localparam int OP_W    = 6;
   localparam int ALUOP_W = 3;
   localparam int STATE_W = 4;

   logic Clk     = 1'b0;
   logic Reset_n = 1'b0;
   int   checks   = 0;
   int   failures = 0;

   multicycle_control_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .STATE_W(STATE_W)) bus ();

   multicycle_control #(
      .OP_W(OP_W), .ALUOP_W(ALUOP_W), .STATE_W(STATE_W), .MEM_HANDSHAKE(1'b1)
   ) dut (
      .Clk(Clk),
      .Reset_n(Reset_n),
      .bus(bus)
   );

   always #5 Clk = ~Clk;

   logic [20:0] obs;
   assign obs = {bus.PCWrite, bus.PCWriteCond, bus.BranchNE, bus.IorD, bus.MemRead,
                 bus.MemWrite, bus.IRWrite, bus.MemtoReg, bus.RegDst, bus.RegWrite,
                 bus.ALUSrcA, bus.ALUSrcB, bus.ALUOp, bus.PCSource, bus.Trap};

   // Expected control word for (state, instruction opcode, MemReady this cycle).
   function automatic logic [20:0] exp_ctrl(input int s, input logic [5:0] op, input logic r);
      logic pcw, pcwc, bne, iord, mr, mw, irw, rw, asa, trap;
      logic [1:0] m2r, rd, asb, pcs;
      logic [2:0] aop;
      {pcw, pcwc, bne, iord, mr, mw, irw, rw, asa, trap} = '0;
      {m2r, rd, asb, pcs} = '0;
      aop = 3'd0;
      case (s)
         0:  begin mr = 1; asb = 2'd1; irw = r; pcw = r; end
         1:  asb = 2'd3;
         2:  begin asa = 1; asb = 2'd2; end
         3:  begin mr = 1; iord = 1; end
         4:  begin rw = 1; m2r = 2'd1; end
         5:  begin mw = 1; iord = 1; end
         6:  begin asa = 1; aop = 3'd2; end
         7:  begin rw = 1; rd = 2'd1; end
         8:  begin asa = 1; aop = 3'd1; pcwc = 1; pcs = 2'd1; bne = (op == 6'd5); end
         9:  begin
                pcw = 1; pcs = 2'd2;
                if (op == 6'd3) begin rw = 1; rd = 2'd2; m2r = 2'd2; end
             end
         10: begin
                asa = 1; asb = 2'd2;
                aop = (op == 6'd10) ? 3'd5 : (op == 6'd12) ? 3'd3 : (op == 6'd13) ? 3'd4 : 3'd0;
             end
         11: rw = 1;
         12: trap = 1;
         default: ;
      endcase
      return {pcw, pcwc, bne, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, pcs, trap};
   endfunction

   int   sq[$];
   logic rq[$];

   task automatic push(input int s, input logic r);
      sq.push_back(s);
      rq.push_back(r);
   endtask

   task automatic check_cycle(input int s, input logic [5:0] op, input logic r, input string tag);
      logic [20:0] want;
      want = exp_ctrl(s, op, r);
      checks++;
      assert (bus.State === STATE_W'(s))
      else begin
         failures++;
         $error("FAIL %s state: got %0d want %0d", tag, bus.State, s);
      end
      checks++;
      assert (obs === want)
      else begin
         failures++;
         $error("FAIL %s ctrl(state %0d): got %h want %h", tag, s, obs, want);
      end
   endtask

   // Expand one instruction into its cycle trace and check it; abort_at>=0 applies reset there.
   task automatic run_instr(input logic [5:0] op, input int fst, input int mst,
                            input string tag, input int abort_at);
      sq.delete();
      rq.delete();
      repeat (fst) push(0, 1'b0);
      push(0, 1'b1);
      push(1, 1'($urandom_range(0, 1)));
      case (op)
         6'd0:  begin push(6, 1'($urandom_range(0, 1))); push(7, 1'($urandom_range(0, 1))); end
         6'd35: begin
                   push(2, 1'($urandom_range(0, 1)));
                   repeat (mst) push(3, 1'b0);
                   push(3, 1'b1);
                   push(4, 1'($urandom_range(0, 1)));
                end
         6'd43: begin
                   push(2, 1'($urandom_range(0, 1)));
                   repeat (mst) push(5, 1'b0);
                   push(5, 1'b1);
                end
         6'd4, 6'd5: push(8, 1'($urandom_range(0, 1)));
         6'd2, 6'd3: push(9, 1'($urandom_range(0, 1)));
         6'd8, 6'd10, 6'd12, 6'd13: begin
                   push(10, 1'($urandom_range(0, 1)));
                   push(11, 1'($urandom_range(0, 1)));
                end
         default: push(12, 1'($urandom_range(0, 1)));
      endcase
      for (int i = 0; i < sq.size(); i++) begin
         @(negedge Clk);
         bus.Op       = (sq[i] == 1) ? op : 6'($urandom);
         bus.MemReady = rq[i];
         #1;
         check_cycle(sq[i], op, rq[i], tag);
         if (i == abort_at) begin
            Reset_n = 1'b0;
            #1;
            check_cycle(0, op, bus.MemReady, {tag, "_async_rst"});
            @(negedge Clk);
            bus.MemReady = 1'b0;
            Reset_n      = 1'b1;
            break;
         end
      end
   endtask

   logic [5:0] legal_ops[11] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd5, 6'd2, 6'd3,
                                 6'd8, 6'd10, 6'd12, 6'd13};

   initial begin
      logic [5:0] op;
      bus.Op       = '0;
      bus.MemReady = 1'b0;
      Reset_n      = 1'b0;
      repeat (2) @(negedge Clk);
      #1;
      check_cycle(0, 6'd0, 1'b0, "reset_hold");
      Reset_n = 1'b1;
      #1;
      check_cycle(0, 6'd0, 1'b0, "reset_release");

      run_instr(6'd35, 0, 0, "lw_nostall", -1);
      run_instr(6'd35, 2, 3, "lw_stall", -1);
      run_instr(6'd5, 0, 0, "bne", -1);
      run_instr(6'd4, 1, 0, "beq", -1);
      run_instr(6'd3, 0, 0, "jal", -1);
      run_instr(6'd2, 0, 0, "j", -1);
      run_instr(6'd13, 0, 0, "ori", -1);
      run_instr(6'd0, 0, 0, "rtype", -1);
      run_instr(6'd63, 0, 0, "illegal", -1);
      run_instr(6'd43, 0, 3, "sw", -1);
      // sw trace: FETCH, DECODE, MEMADR, MEMWR(stall)... -> reset in the second MEMWR cycle
      run_instr(6'd43, 0, 5, "sw_reset", 4);
      run_instr(6'd35, 0, 1, "lw_after_reset", -1);

      for (int n = 0; n < 80; n++) begin
         if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 10)];
         else                           op = 6'($urandom);
         run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3), "random", -1);
      end
      run_instr(6'd8, 0, 0, "final_addi", -1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
